costas_gear_ctrl: RTL and testbench
===================================

Name: costas_gear_ctrl

Overview:
- Loop-bandwidth scheduler ("gear shifter") for the Costas loop NCO phase block.
- Watches the phase-error stream and drives that block's FEEDBACK_SHIFT and enable.
- Acquires with a wide loop (small shift), steps to a narrow tracking loop as the error settles, declares lock, and falls back to acquisition on sustained loss.

Parameters:
- WIDTH, 16, width of signed phase-error samples
- SHIFT_ACQ, 2, feedback shift used during acquisition (wide bandwidth)
- SHIFT_TRACK, 8, final tracking shift; must be >= SHIFT_ACQ and <= 15
- DWELL, 1024, consecutive quiet samples required per gear step
- LOSS_COUNT, 64, consecutive loud samples in LOCKED that force re-acquisition
- CNT_WIDTH, 16, width of the dwell and loss counters; must hold max(DWELL, LOSS_COUNT)

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, synchronous active-low reset
- enable, in, 1, run/freeze control from the upstream sequencer
- force_reacq, in, 1, single-cycle pulse: restart acquisition
- lock_thresh, in, WIDTH-1, magnitude threshold (unsigned) separating quiet from loud samples
- err_tdata, in, WIDTH, signed phase error from the Costas detector/loop filter
- err_tvalid, in, 1, err_tdata valid
- feedback_shift, out, 4, to NCO phase FEEDBACK_SHIFT
- nco_enable, out, 1, to NCO phase enable
- locked, out, 1, high while in LOCKED
- gear_change, out, 1, one-cycle pulse on every feedback_shift change
- state, out, 2, 0=IDLE, 1=ACQUIRE, 2=LOCKED

Behaviour:
- Synchronous active-low reset; all outputs are registered.
- Reset values: state=IDLE, feedback_shift=SHIFT_ACQ, nco_enable=0, locked=0, gear_change=0, both counters=0.
- Magnitude |err|: saturating, so -2^(WIDTH-1) maps to 2^(WIDTH-1)-1. A sample is quiet iff |err| < lock_thresh; otherwise it is loud.
- Only samples with err_tvalid=1 and enable=1 are evaluated. All others are ignored and the counters hold.
- nco_enable = enable, delayed one cycle. In any state, enable=0 freezes state, shift and counters.
- gear_change defaults to 0 each cycle.
- IDLE:
  - Goes to ACQUIRE on the first cycle with enable=1.
  - feedback_shift=SHIFT_ACQ; dwell_cnt is cleared.
- ACQUIRE:
  - A quiet sample increments dwell_cnt; a loud sample clears it.
  - Gear step: on a quiet sample with dwell_cnt==DWELL-1:
    - if feedback_shift<SHIFT_TRACK: feedback_shift+1, dwell_cnt=0, gear_change=1 next cycle;
    - if feedback_shift==SHIFT_TRACK: go to LOCKED, locked=1, dwell_cnt=0, loss_cnt=0. No gear_change.
  - A step takes effect on the cycle after the triggering sample (1-cycle latency).
- LOCKED:
  - A loud sample increments loss_cnt; a quiet sample clears it.
  - On a loud sample with loss_cnt==LOSS_COUNT-1: go to ACQUIRE, feedback_shift=SHIFT_ACQ, locked=0, gear_change=1, counters cleared.
- force_reacq=1 with enable=1, from ACQUIRE or LOCKED:
  - same action as a loss event; overrides any sample evaluated in the same cycle;
  - gear_change=1 only if feedback_shift was not already SHIFT_ACQ.
- force_reacq in IDLE, or with enable=0: ignored.
- SHIFT_ACQ==SHIFT_TRACK: no steps occur; LOCKED is reached after DWELL quiet samples.
- Counters never wrap; each comparison is an equality test against its limit.
- rst_n low mid-operation: next edge gives reset values regardless of other inputs.

Decomposition:
- Shared package:
  - state encoding constants (IDLE/ACQUIRE/LOCKED);
  - SHIFT_ACQ/SHIFT_TRACK defaults;
  - 4-bit shift width constant, also used by the NCO phase block.
- One sub-module, err_mag_cmp:
  - registered-free saturating |x| plus less-than compare;
  - outputs quiet/loud qualified by valid.
- Sequencing FSM and counters stay in costas_gear_ctrl.

Test Plan (DWELL=4, LOSS_COUNT=3, SHIFT_ACQ=2, SHIFT_TRACK=4, lock_thresh=100):
- Reset, then enable=1 with a stream of err=10 → IDLE→ACQUIRE; shift 2→3 after sample 4, →4 after sample 8 (gear_change pulses each time); LOCKED and locked=1 after sample 12.
- In ACQUIRE at shift=2, feed 3 quiet samples, then err=-100, then 4 quiet → no step until the 4th quiet after the loud sample; err=-100 counts as loud.
- Locked, feed err=500, 500, 20, 500, 500, 500 → no loss after the first pair; the third consecutive loud sample sends state→ACQUIRE, shift=2, locked=0, one gear_change pulse.
- err=-32768 (saturation) while locked, 3 times → treated as loud; loss declared.
- enable=0 for 10 cycles mid-dwell while valid samples arrive → nco_enable drops 1 cycle later; counters and shift frozen; resuming continues the count.
- force_reacq coincident with the 4th quiet sample at shift=3 → shift=2 (not 4), gear_change=1; then rst_n=0 for 1 cycle → all outputs at reset values.

Source files
------------

// File: rtl/costas_gear_ctrl_pkg.sv
// Shared definitions for the Costas loop gear shifter and the NCO phase block.
package costas_gear_ctrl_pkg;

  // Width of the FEEDBACK_SHIFT field understood by the NCO phase block.
  localparam int SHIFT_W = 4;

  // Default gears: wide loop while acquiring, narrow loop once tracking.
  localparam int DEF_SHIFT_ACQ   = 2;
  localparam int DEF_SHIFT_TRACK = 8;

  // Sequencer state encoding; visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } gear_state_e;

endpackage

// File: rtl/costas_gear_ctrl_err_mag_cmp.sv
// Saturating magnitude of a signed phase-error sample compared against an
// unsigned threshold. Purely combinational; quiet/loud are qualified by valid.
module err_mag_cmp #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_valid,
  input  logic        [WIDTH-2:0] i_thresh,
  output logic                    o_quiet,
  output logic                    o_loud
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_neg;
  logic [WIDTH-2:0] w_mag;
  logic             w_below;

  assign w_neg = -i_data;

  // |x| with the most negative value clamped to the largest positive magnitude.
  always_comb begin
    w_mag = i_data[WIDTH-2:0];
    if (i_data[WIDTH-1]) begin
      if (i_data == MIN_VAL) w_mag = '1;
      else                   w_mag = w_neg[WIDTH-2:0];
    end
  end

  assign w_below = (w_mag < i_thresh);
  assign o_quiet = i_valid & w_below;
  assign o_loud  = i_valid & ~w_below;

endmodule

// File: rtl/costas_gear_ctrl.sv
// Loop-bandwidth scheduler for the Costas NCO phase block: acquires with a
// wide loop, steps the feedback shift up as the error settles, declares lock,
// and falls back to acquisition on sustained loss or on request.
//
// Handshake: a phase-error sample is consumed only on a cycle where
// err_tvalid=1 and enable=1; there is no ready, the block always accepts.
module costas_gear_ctrl
  import costas_gear_ctrl_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SHIFT_ACQ   = DEF_SHIFT_ACQ,
  parameter int SHIFT_TRACK = DEF_SHIFT_TRACK,
  parameter int DWELL       = 1024,
  parameter int LOSS_COUNT  = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      force_reacq,
  input  logic        [WIDTH-2:0]   lock_thresh,
  input  logic signed [WIDTH-1:0]   err_tdata,
  input  logic                      err_tvalid,
  output logic        [SHIFT_W-1:0] feedback_shift,
  output logic                      nco_enable,
  output logic                      locked,
  output logic                      gear_change,
  output logic        [1:0]         state
);

  localparam logic [SHIFT_W-1:0]   ACQ_S      = SHIFT_W'(SHIFT_ACQ);
  localparam logic [SHIFT_W-1:0]   TRACK_S    = SHIFT_W'(SHIFT_TRACK);
  localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL - 1);
  localparam logic [CNT_WIDTH-1:0] LOSS_LAST  = CNT_WIDTH'(LOSS_COUNT - 1);

  gear_state_e          r_state, w_state_nxt;
  logic [SHIFT_W-1:0]   r_shift, w_shift_nxt;
  logic [CNT_WIDTH-1:0] r_dwell, w_dwell_nxt;
  logic [CNT_WIDTH-1:0] r_loss,  w_loss_nxt;
  logic                 r_gear,  w_gear_nxt;
  logic                 r_locked;
  logic                 r_nco_en;

  logic w_quiet;
  logic w_loud;
  logic w_dwell_done;
  logic w_loss_done;

  err_mag_cmp #(
    .WIDTH (WIDTH)
  ) u_err_mag_cmp (
    .i_data   (err_tdata),
    .i_valid  (err_tvalid & enable),
    .i_thresh (lock_thresh),
    .o_quiet  (w_quiet),
    .o_loud   (w_loud)
  );

  assign w_dwell_done = w_quiet && (r_dwell == DWELL_LAST);
  assign w_loss_done  = w_loud  && (r_loss  == LOSS_LAST);

  // State and datapath registers; enable=0 makes every next value a hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shift  <= ACQ_S;
      r_dwell  <= '0;
      r_loss   <= '0;
      r_gear   <= 1'b0;
      r_locked <= 1'b0;
      r_nco_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_dwell  <= w_dwell_nxt;
      r_loss   <= w_loss_nxt;
      r_gear   <= w_gear_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
      r_nco_en <= enable;
    end
  end

  // Next state: force_reacq outranks any sample seen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (enable) begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: if (!force_reacq && w_dwell_done && !(r_shift < TRACK_S))
                      w_state_nxt = ST_LOCKED;
        ST_LOCKED:  if (force_reacq || w_loss_done)
                      w_state_nxt = ST_ACQUIRE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next shift, counters and gear_change pulse for the current state.
  always_comb begin
    w_shift_nxt = r_shift;
    w_dwell_nxt = r_dwell;
    w_loss_nxt  = r_loss;
    w_gear_nxt  = 1'b0;
    if (enable) begin
      case (r_state)
        ST_IDLE: begin
          w_shift_nxt = ACQ_S;
          w_dwell_nxt = '0;
        end
        ST_ACQUIRE: begin
          if (force_reacq) begin
            w_shift_nxt = ACQ_S;
            w_dwell_nxt = '0;
            w_loss_nxt  = '0;
            w_gear_nxt  = (r_shift != ACQ_S);
          end else if (w_dwell_done) begin
            w_dwell_nxt = '0;
            if (r_shift < TRACK_S) begin
              w_shift_nxt = r_shift + 1'b1;
              w_gear_nxt  = 1'b1;
            end else begin
              w_loss_nxt = '0;
            end
          end else if (w_quiet) begin
            w_dwell_nxt = r_dwell + 1'b1;
          end else if (w_loud) begin
            w_dwell_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (force_reacq || w_loss_done) begin
            w_shift_nxt = ACQ_S;
            w_dwell_nxt = '0;
            w_loss_nxt  = '0;
            w_gear_nxt  = (r_shift != ACQ_S);
          end else if (w_loud) begin
            w_loss_nxt = r_loss + 1'b1;
          end else if (w_quiet) begin
            w_loss_nxt = '0;
          end
        end
        default: begin
          w_shift_nxt = ACQ_S;
          w_dwell_nxt = '0;
          w_loss_nxt  = '0;
        end
      endcase
    end
  end

  assign feedback_shift = r_shift;
  assign nco_enable     = r_nco_en;
  assign locked         = r_locked;
  assign gear_change    = r_gear;
  assign state          = r_state;

endmodule

// File: tb/tb_costas_gear_ctrl.sv
// Directed bench for costas_gear_ctrl with DWELL=4, LOSS_COUNT=3,
// SHIFT_ACQ=2, SHIFT_TRACK=4, lock_thresh=100.
module tb_costas_gear_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               force_reacq;
  logic [14:0]        lock_thresh;
  logic signed [15:0] err_tdata;
  logic               err_tvalid;
  logic [3:0]         feedback_shift;
  logic               nco_enable;
  logic               locked;
  logic               gear_change;
  logic [1:0]         state;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed output bundle: {state, shift, locked, gear_change, nco_enable}.
  logic [8:0] obs;
  assign obs = {state, feedback_shift, locked, gear_change, nco_enable};

  costas_gear_ctrl #(
    .WIDTH       (16),
    .SHIFT_ACQ   (2),
    .SHIFT_TRACK (4),
    .DWELL       (4),
    .LOSS_COUNT  (3),
    .CNT_WIDTH   (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .force_reacq    (force_reacq),
    .lock_thresh    (lock_thresh),
    .err_tdata      (err_tdata),
    .err_tvalid     (err_tvalid),
    .feedback_shift (feedback_shift),
    .nco_enable     (nco_enable),
    .locked         (locked),
    .gear_change    (gear_change),
    .state          (state)
  );

  // Clock block.
  always #5 clk = ~clk;

  function automatic logic [8:0] mk(input logic [1:0] st, input logic [3:0] sh,
                                    input logic lk, input logic gc, input logic ne);
    return {st, sh, lk, gc, ne};
  endfunction

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic signed [15:0] e);
    err_tdata  = e;
    err_tvalid = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; force_reacq = 1'b0;
    err_tvalid = 1'b0; err_tdata = '0; lock_thresh = 15'd100;
    tick(); tick();
    n_checks++;
    if (obs !== mk(2'd0, 4'd2, 1'b0, 1'b0, 1'b0))
      $display("FAIL reset_values: got %h expected %h", obs, mk(2'd0, 4'd2, 1'b0, 1'b0, 1'b0));
    else n_pass++;
    rst_n = 1'b1;
    force_reacq = 1'b1;
    tick();
    force_reacq = 1'b0;
    n_checks++;
    if (obs !== mk(2'd0, 4'd2, 1'b0, 1'b0, 1'b0))
      $display("FAIL idle_ignores_force: got %h expected %h", obs, mk(2'd0, 4'd2, 1'b0, 1'b0, 1'b0));
    else n_pass++;
  endtask

  task automatic test_acquire_steps();
    logic [3:0] esh;
    logic       egc;
    logic [1:0] est;
    enable = 1'b1; err_tvalid = 1'b0;
    tick();
    n_checks++;
    if (obs !== mk(2'd1, 4'd2, 1'b0, 1'b0, 1'b1))
      $display("FAIL idle_to_acquire: got %h expected %h", obs, mk(2'd1, 4'd2, 1'b0, 1'b0, 1'b1));
    else n_pass++;
    for (int i = 1; i <= 12; i++) begin
      sample(16'sd10);
      esh = (i >= 8) ? 4'd4 : (i >= 4) ? 4'd3 : 4'd2;
      egc = (i == 4) || (i == 8);
      est = (i == 12) ? 2'd2 : 2'd1;
      n_checks++;
      if (obs !== mk(est, esh, (i == 12), egc, 1'b1))
        $display("FAIL acq_sample_%0d: got %h expected %h", i, obs, mk(est, esh, (i == 12), egc, 1'b1));
      else n_pass++;
    end
  endtask

  task automatic test_loss();
    logic signed [15:0] seq [6];
    seq = '{16'sd500, 16'sd500, 16'sd20, 16'sd500, 16'sd500, 16'sd500};
    for (int i = 0; i < 6; i++) begin
      sample(seq[i]);
      if (i < 5) begin
        n_checks++;
        if (obs !== mk(2'd2, 4'd4, 1'b1, 1'b0, 1'b1))
          $display("FAIL loss_hold_%0d: got %h expected %h", i, obs, mk(2'd2, 4'd4, 1'b1, 1'b0, 1'b1));
        else n_pass++;
      end
    end
    n_checks++;
    if (obs !== mk(2'd1, 4'd2, 1'b0, 1'b1, 1'b1))
      $display("FAIL loss_declared: got %h expected %h", obs, mk(2'd1, 4'd2, 1'b0, 1'b1, 1'b1));
    else n_pass++;
    err_tvalid = 1'b0;
    tick();
    n_checks++;
    if (obs !== mk(2'd1, 4'd2, 1'b0, 1'b0, 1'b1))
      $display("FAIL loss_pulse_end: got %h expected %h", obs, mk(2'd1, 4'd2, 1'b0, 1'b0, 1'b1));
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 12; i++) sample(-16'sd7);
    n_checks++;
    if (obs !== mk(2'd2, 4'd4, 1'b1, 1'b0, 1'b1))
      $display("FAIL relock: got %h expected %h", obs, mk(2'd2, 4'd4, 1'b1, 1'b0, 1'b1));
    else n_pass++;
    sample(16'sh8000);
    sample(16'sh8000);
    n_checks++;
    if (obs !== mk(2'd2, 4'd4, 1'b1, 1'b0, 1'b1))
      $display("FAIL sat_two_loud: got %h expected %h", obs, mk(2'd2, 4'd4, 1'b1, 1'b0, 1'b1));
    else n_pass++;
    sample(16'sh8000);
    n_checks++;
    if (obs !== mk(2'd1, 4'd2, 1'b0, 1'b1, 1'b1))
      $display("FAIL sat_loss: got %h expected %h", obs, mk(2'd1, 4'd2, 1'b0, 1'b1, 1'b1));
    else n_pass++;
  endtask

  task automatic test_acq_loud_reset();
    logic signed [15:0] seq [8];
    // 99 and -99 sit just under the threshold; -100 sits exactly on it (loud).
    seq = '{16'sd99, -16'sd99, 16'sd10, -16'sd100, 16'sd10, 16'sd10, 16'sd10, 16'sd10};
    for (int i = 0; i < 8; i++) begin
      sample(seq[i]);
      n_checks++;
      if (i < 7) begin
        if (obs !== mk(2'd1, 4'd2, 1'b0, 1'b0, 1'b1))
          $display("FAIL acq_dwell_%0d: got %h expected %h", i, obs, mk(2'd1, 4'd2, 1'b0, 1'b0, 1'b1));
        else n_pass++;
      end else begin
        if (obs !== mk(2'd1, 4'd3, 1'b0, 1'b1, 1'b1))
          $display("FAIL acq_step_after_loud: got %h expected %h", obs, mk(2'd1, 4'd3, 1'b0, 1'b1, 1'b1));
        else n_pass++;
      end
    end
  endtask

  task automatic test_enable_freeze();
    sample(16'sd10);
    sample(16'sd10);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      force_reacq = (i == 4);
      sample(16'sd10);
      n_checks++;
      if (obs !== mk(2'd1, 4'd3, 1'b0, 1'b0, 1'b0))
        $display("FAIL freeze_%0d: got %h expected %h", i, obs, mk(2'd1, 4'd3, 1'b0, 1'b0, 1'b0));
      else n_pass++;
    end
    force_reacq = 1'b0;
    enable = 1'b1;
    sample(16'sd10);
    n_checks++;
    if (obs !== mk(2'd1, 4'd3, 1'b0, 1'b0, 1'b1))
      $display("FAIL resume_count: got %h expected %h", obs, mk(2'd1, 4'd3, 1'b0, 1'b0, 1'b1));
    else n_pass++;
  endtask

  task automatic test_force_and_reset();
    force_reacq = 1'b1;
    sample(16'sd10);
    force_reacq = 1'b0;
    n_checks++;
    if (obs !== mk(2'd1, 4'd2, 1'b0, 1'b1, 1'b1))
      $display("FAIL force_overrides_step: got %h expected %h", obs, mk(2'd1, 4'd2, 1'b0, 1'b1, 1'b1));
    else n_pass++;
    force_reacq = 1'b1;
    sample(16'sd10);
    n_checks++;
    if (obs !== mk(2'd1, 4'd2, 1'b0, 1'b0, 1'b1))
      $display("FAIL force_at_acq_no_pulse: got %h expected %h", obs, mk(2'd1, 4'd2, 1'b0, 1'b0, 1'b1));
    else n_pass++;
    rst_n = 1'b0;
    sample(16'sd500);
    n_checks++;
    if (obs !== mk(2'd0, 4'd2, 1'b0, 1'b0, 1'b0))
      $display("FAIL mid_reset: got %h expected %h", obs, mk(2'd0, 4'd2, 1'b0, 1'b0, 1'b0));
    else n_pass++;
    rst_n = 1'b1; force_reacq = 1'b0; err_tvalid = 1'b0;
    tick();
    n_checks++;
    if (obs !== mk(2'd1, 4'd2, 1'b0, 1'b0, 1'b1))
      $display("FAIL restart_after_reset: got %h expected %h", obs, mk(2'd1, 4'd2, 1'b0, 1'b0, 1'b1));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_acquire_steps();
    test_loss();
    test_saturation();
    test_acq_loud_reset();
    test_enable_freeze();
    test_force_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
